// File: rtl/gate_result_checker_if.sv
// ----------------------------------------------------------------------------
// gate_result_checker_if
// Sample handshake between a gate-under-test harness and the result checker.
//   in_valid : upstream has a sample on in_a/in_b/in_res
//   in_ready : checker can accept a sample this cycle
//   in_a     : operand a
//   in_b     : operand b
//   in_res   : observed gate results {XNOR,XOR,NOR,NAND,NOT(a),OR,AND}
// master = sample source, slave = checker.
// ----------------------------------------------------------------------------
interface gate_result_checker_if;
   logic       in_valid;
   logic       in_ready;
   logic       in_a;
   logic       in_b;
   logic [6:0] in_res;

   modport master (output in_valid, in_a, in_b, in_res, input in_ready);
   modport slave  (input in_valid, in_a, in_b, in_res, output in_ready);
endinterface

// File: rtl/gate_result_checker.sv
// ----------------------------------------------------------------------------
// gate_result_checker
// Checks the seven basic gate outputs for each accepted (a,b) sample, keeps
// per-run error / sample / operand-coverage statistics and flags the run as
// passed once SAMPLE_TARGET samples were accepted with no error and all four
// operand combinations seen.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start        : one-cycle request to clear results and (re)start a run
//   in_if        : sample handshake (slave side)
//   err_flag     : one-cycle pulse after a mismatching sample
//   err_mask     : per-bit mismatch of the last accepted sample
//   err_count    : mismatching samples in this run (saturating)
//   sample_count : samples accepted in this run
//   cov_map      : bit {a,b} set once that operand pair was accepted
//   done, pass   : run complete / run complete and clean with full coverage
// ----------------------------------------------------------------------------
module gate_result_checker #(
   parameter int unsigned SAMPLE_TARGET = 4,
   parameter int unsigned ERR_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   gate_result_checker_if.slave in_if,
   output logic                 err_flag,
   output logic [6:0]           err_mask,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic [7:0]           sample_count,
   output logic [3:0]           cov_map,
   output logic                 done,
   output logic                 pass
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Count value held just before the transfer that completes the run.
   localparam logic [7:0] LAST_IDX = 8'(SAMPLE_TARGET - 1);

   state_t                state_q, state_d;
   logic                  err_flag_q, err_flag_d;
   logic [6:0]            err_mask_q, err_mask_d;
   logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
   logic [7:0]            sample_count_q, sample_count_d;
   logic [3:0]            cov_map_q, cov_map_d;

   logic                  ready_c;
   logic                  done_c;
   logic                  xfer;
   logic [6:0]            expected;
   logic [6:0]            mismatch;

   // A start in the same cycle wins: the sample is dropped, not counted.
   assign xfer = in_if.in_valid & ready_c & ~start;

   assign expected = {~(in_if.in_a ^ in_if.in_b),
                       in_if.in_a ^ in_if.in_b,
                      ~(in_if.in_a | in_if.in_b),
                      ~(in_if.in_a & in_if.in_b),
                      ~in_if.in_a,
                       in_if.in_a | in_if.in_b,
                       in_if.in_a & in_if.in_b};
   assign mismatch = in_if.in_res ^ expected;

   // ---------------- FSM: state register ----------------
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      // NOTE: default assignment first so no path leaves state_d unassigned,
      // which would otherwise infer a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            if (start)                                   state_d = RUN;
            else if (xfer && sample_count_q == LAST_IDX) state_d = DONE;
         end
         DONE: if (start) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ready_c = 1'b0;
      done_c  = 1'b0;
      unique case (state_q)
         RUN:     ready_c = 1'b1;
         DONE:    done_c  = 1'b1;
         default: ;
      endcase
   end

   // ---------------- result datapath ----------------
   always_comb begin
      err_flag_d     = 1'b0;
      err_mask_d     = err_mask_q;
      err_count_d    = err_count_q;
      sample_count_d = sample_count_q;
      cov_map_d      = cov_map_q;
      if (start) begin
         err_mask_d     = '0;
         err_count_d    = '0;
         sample_count_d = '0;
         cov_map_d      = '0;
      end else if (xfer) begin
         err_mask_d     = mismatch;
         err_flag_d     = |mismatch;
         sample_count_d = sample_count_q + 8'd1;
         cov_map_d      = cov_map_q | (4'b0001 << {in_if.in_a, in_if.in_b});
         if (|mismatch && err_count_q != '1)
            err_count_d = err_count_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_flag_q     <= 1'b0;
         err_mask_q     <= '0;
         err_count_q    <= '0;
         sample_count_q <= '0;
         cov_map_q      <= '0;
      end else begin
         err_flag_q     <= err_flag_d;
         err_mask_q     <= err_mask_d;
         err_count_q    <= err_count_d;
         sample_count_q <= sample_count_d;
         cov_map_q      <= cov_map_d;
      end
   end

   assign in_if.in_ready = ready_c;
   assign done           = done_c;
   assign err_flag       = err_flag_q;
   assign err_mask       = err_mask_q;
   assign err_count      = err_count_q;
   assign sample_count   = sample_count_q;
   assign cov_map        = cov_map_q;
   assign pass           = done_c && (err_count_q == '0) && (cov_map_q == 4'hF);

endmodule

// File: doc/gate_result_checker.md
GATE_RESULT_CHECKER -- requirements
Module: gate_result_checker

Interface
REQ-001 The block SHALL have parameter SAMPLE_TARGET, default 4, the number of accepted samples that ends a run (legal range 1..255).
REQ-002 The block SHALL have parameter ERR_CNT_W, default 8, the width of the error counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to clear results and begin a run.
REQ-006 The block SHALL have port in_valid, input, 1, upstream sample valid.
REQ-007 The block SHALL have port in_ready, output, 1, checker can accept a sample.
REQ-008 The block SHALL have ports in_a and in_b, input, 1 each, the gate-under-test operands.
REQ-009 The block SHALL have port in_res, input, 7, the gate results: bit0 AND, bit1 OR, bit2 NOT(a), bit3 NAND, bit4 NOR, bit5 XOR, bit6 XNOR.
REQ-010 The block SHALL have port err_flag, output, 1, a one-cycle pulse when the last accepted sample mismatched.
REQ-011 The block SHALL have port err_mask, output, 7, the registered per-bit mismatch of the last accepted sample, in in_res bit order.
REQ-012 The block SHALL have port err_count, output, ERR_CNT_W, the number of mismatching samples in the current run.
REQ-013 The block SHALL have port sample_count, output, 8, the number of samples accepted in the current run.
REQ-014 The block SHALL have port cov_map, output, 4, where bit {in_a,in_b} is set once that operand combination is accepted.
REQ-015 The block SHALL have ports done and pass, output, 1 each, for run complete and run passed.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 The FSM SHALL move from IDLE or DONE to RUN on start=1, clearing err_mask, err_count, sample_count and cov_map on that edge.
REQ-018 start=1 in RUN SHALL restart the run with the same clearing, and any transfer in that cycle SHALL be discarded.
REQ-019 in_ready SHALL be 1 only in RUN, derived combinationally from state.
REQ-020 A transfer SHALL occur only when in_valid=1 and in_ready=1 and start=0; in_valid with in_ready=0 SHALL be ignored, not queued.
REQ-021 The expected vector for each transfer SHALL be {a~^b, a^b, ~(a|b), ~(a&b), ~a, a|b, a&b}, packed MSB to LSB.
REQ-022 On a transfer, err_mask SHALL load in_res XOR expected, registered, so it is visible one cycle after the transfer.
REQ-023 err_flag SHALL be 1 for exactly the cycle after a transfer whose mismatch is nonzero, and 0 otherwise; back-to-back mismatching transfers SHALL give consecutive pulses.
REQ-024 On a mismatching transfer, err_count SHALL increment and saturate at all-ones with no wrap.
REQ-025 On every transfer, sample_count SHALL increment and cov_map SHALL OR in bit {in_a,in_b}.
REQ-026 The transfer that makes sample_count equal SAMPLE_TARGET SHALL move RUN to DONE on the same edge, so the next cycle has in_ready=0.
REQ-027 done SHALL be 1 exactly when the state is DONE.
REQ-028 pass SHALL be 1 only when done=1, err_count=0 and cov_map=4'hF.
REQ-029 In DONE, all result outputs SHALL hold their values until start or rst.
REQ-030 In IDLE, the outputs SHALL hold their reset values.

Reset
REQ-031 When rst=1 at a clock edge, the state SHALL become IDLE and in_ready, err_flag, done and pass SHALL be 0, err_mask 7'h00, err_count 0, sample_count 0 and cov_map 4'h0.
REQ-032 rst SHALL take priority over start and in_valid, including in the middle of a run.
REQ-033 After rst deasserts, no transfer SHALL be accepted until start is pulsed.

Verification
REQ-034 Reset, pulse start, then drive the four (a,b) combinations 00,01,10,11 with correct in_res back-to-back -> sample_count=4, cov_map=F, err_count=0, done=1, pass=1, in_ready=0.
REQ-035 A run where (a,b)=(1,0) carries in_res XOR bit on XOR -> err_flag pulses one cycle after that transfer, err_mask=7'h20, err_count=1, pass=0.
REQ-036 Drive four correct samples all with (a,b)=(0,0) -> done=1, cov_map=4'h1, pass=0.
REQ-037 Assert rst after two transfers, then drive in_valid without start -> all outputs zero and in_ready=0; no count changes.
REQ-038 With ERR_CNT_W=2 and SAMPLE_TARGET=6, drive six mismatching samples -> err_count stays 3 and err_flag pulses six times.
REQ-039 Assert start in the same cycle as in_valid in RUN -> counters clear, the sample is not counted, and sample_count=0 the next cycle.
